// File: rtl/uart_tx_sched_if.sv
// Requester-side byte bus for uart_tx_sched: per-channel valid/data in, one-hot ready back.
// Ready is combinational from the scheduler; a byte moves when valid and ready are both high.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter + 8N1 serializer on one tx line; one byte per frame, bit timing from txclk_en.
// Ready is offered only while idle or on the final stop tick, so back-to-back frames have no idle bit.
module uart_tx_sched #(
  parameter  int NUM_REQ   = 4,
  parameter  int STOP_BITS = 1,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic            clk_50m,
  input  logic            rst_n,
  input  logic            txclk_en,
  uart_tx_sched_if.slave  req,
  output logic            tx,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_cnt_q, stop_cnt_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               accept;
  logic [NUM_REQ-1:0] ready_vec;

  // Search starts one past the last winner, so the last served channel has lowest priority.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (txclk_en) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (txclk_en) begin
          tx_d      = shreg_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (txclk_en) begin
          if (bit_idx_q == 3'd7) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            tx_d      = shreg_q[bit_idx_q + 3'd1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (txclk_en) begin
          if ((STOP_BITS == 2) && (stop_cnt_q == 1'b0)) begin
            stop_cnt_d = 1'b1;
          end else if (win_found) begin
            // Next frame's start bit replaces the idle bit directly.
            accept  = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shreg_d = req.req_data[8*win_id +: 8];
      gid_d   = win_id;
      ptr_d   = win_id;
      busy_d  = 1'b1;
    end
  end

  always_comb begin
    ready_vec = '0;
    ready_vec[win_id] = accept & rst_n;
  end

  assign req.req_ready = ready_vec;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      gid_q      <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      shreg_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      gid_q      <= gid_d;
      ptr_q      <= ptr_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler and 8N1 serializer that shares the single UART transmit line between NUM_REQ byte requesters. Bit timing comes only from the txclk_en strobe of the baud rate generator (one pulse per bit period). The block sits between the peripheral's byte sources (command responses, status, debug) and the tx pin. It arbitrates between requesters, accepts one byte per frame and shifts it out LSB first.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
ID_W, $clog2(NUM_REQ), width of grant_id (derived, do not override)

Ports:
clk_50m  in  1  system clock; all state is updated on its rising edge
rst_n  in  1  asynchronous active-low reset
txclk_en  in  1  bit-period strobe from the baud rate generator, one clk_50m cycle wide
req_valid  in  NUM_REQ  per-channel byte valid
req_data  in  8*NUM_REQ  per-channel byte; channel i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot accept strobe; byte i is transferred when req_valid[i] and req_ready[i] are both high
tx  out  1  serial output (registered); idle level is high
busy  out  1  high from byte acceptance until the last stop bit ends
grant_id  out  ID_W  channel of the current or most recent frame

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE.
  - Round-robin pointer = NUM_REQ-1, so channel 0 wins the first arbitration.
  - Reset mid-frame aborts the frame immediately. tx returns high. The byte is lost and is not re-requested.
- States: IDLE, WAIT, START, DATA, STOP.
- Arbitration:
  - Winner is the first channel with req_valid high, searching from pointer+1 upward with wrap-around.
  - req_ready is combinational: req_ready[winner]=1 only in an accept cycle, all other bits 0.
  - On accept: the byte is captured into the shift register, grant_id<=winner, pointer<=winner, busy<=1.
- Requester rules:
  - Requesters hold valid and data stable until ready is seen.
  - Valid may drop before a grant is given; the block tolerates this and does not latch any state from an ungranted channel.
- IDLE:
  - If any req_valid is high, accept and go to WAIT.
  - A txclk_en pulse in the accept cycle is ignored.
- WAIT: on txclk_en, tx<=0 and go to START.
- START: on txclk_en, tx<=d[0], bit_idx<=0, go to DATA.
- DATA: on txclk_en:
  - if bit_idx==7: tx<=1, stop_cnt<=0, go to STOP;
  - else: tx<=d[bit_idx+1], bit_idx<=bit_idx+1.
- STOP: on txclk_en:
  - if stop_cnt<STOP_BITS-1: stop_cnt<=stop_cnt+1;
  - else, if any req_valid: accept in this cycle, tx<=0, go to START (back-to-back frames, no idle bit);
  - else: busy<=0, go to IDLE.
- tx changes only on a clk_50m edge where txclk_en=1, except for reset. Each bit lasts exactly one txclk_en period.
- No txclk_en pulses: the block holds its state indefinitely. WAIT stays pending; no timeout.
- A frame, once started, is never pre-empted. New requests only affect the next arbitration.
- req_ready is never asserted outside IDLE, or outside the final STOP tick.

Test Plan:
1. Single byte. Reset, txclk_en every 4 cycles, req_valid=0001, data0=0xA5 -> req_ready=0001 for 1 cycle. tx sequence per tick is 0,1,0,1,0,0,1,0,1,1. busy falls on the tick that ends the stop bit. grant_id=0.
2. Round-robin fairness. All 4 valid continuously, data_i=0x10+i -> grants in order 0,1,2,3,0. Frames are back-to-back with no idle bit between stop and start. Each ready pulse coincides with the final stop tick.
3. Skipping. Valid=1010 after channel 1 was last granted -> channel 3 is granted, then channel 1. Valid toggled on channel 2 while 3 is mid-frame -> 2 is not granted until 3's final stop tick.
4. STOP_BITS=2. Byte 0xFF -> tx low for 1 bit period, high for 10. Back-to-back next frame starts exactly after 2 stop periods.
5. Reset mid-frame. Assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 within the same cycle, without waiting for a clock. After release, valid=0100 -> channel 2 is granted. The pointer restarts from NUM_REQ-1, so channel 0 would win if also valid.
6. Stalled baud. txclk_en held 0 after accept -> state stays WAIT, tx=1, busy=1, req_ready=0 for 1000 cycles. The first subsequent pulse drives the start bit.
